// File: rtl/fft2d_tile_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fft2d_tile_feeder
// Brief    : Streams a run of 4x4 complex tiles from image memory into the
//            2D FFT, one frame per fft_next pulse, with back-pressure and stride.
// Revision : 1.0 - initial release
// ============================================================================
module fft2d_tile_feeder #(
    parameter int ADDR_WIDTH  = 13,
    parameter int MEM_LATENCY = 1,
    parameter int FFT_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] addr_stride_i,
    input  logic [ADDR_WIDTH:0]   num_tiles_i,
    output logic [ADDR_WIDTH-1:0] mem_raddr_o,
    input  logic [1023:0]         mem_rdata_i,
    input  logic                  fft_ready_i,
    output logic [1023:0]         fft_in_o,
    output logic                  fft_next_o,
    output logic                  busy_o,
    output logic                  done_o
);

    // One counter serves both the WAIT and GAP phases, sized for the longer one.
    localparam int c_CNT_MAX = (MEM_LATENCY > FFT_GAP) ? MEM_LATENCY : FFT_GAP;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_LAT_LAST = c_CNT_W'(MEM_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'((FFT_GAP > 0) ? FFT_GAP - 1 : 0);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_READ  = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_ISSUE = 3'd3;
    localparam logic [2:0] c_GAP   = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    logic [2:0]            state_q,  state_d;
    logic [ADDR_WIDTH-1:0] raddr_q,  raddr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic [c_CNT_W-1:0]    cnt_q,    cnt_d;
    logic [1023:0]         fft_in_q, fft_in_d;
    logic                  busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= c_IDLE;
            raddr_q  <= '0;
            stride_q <= '0;
            remain_q <= '0;
            cnt_q    <= '0;
            fft_in_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            raddr_q  <= raddr_d;
            stride_q <= stride_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
            fft_in_q <= fft_in_d;
            busy_q   <= (state_d != c_IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        raddr_d  = raddr_q;
        stride_d = stride_q;
        remain_d = remain_q;
        cnt_d    = cnt_q;
        fft_in_d = fft_in_q;
        case (state_q)
            c_IDLE: begin
                if (start_i) begin
                    stride_d = addr_stride_i;
                    if (num_tiles_i == '0) begin
                        state_d = c_DONE;
                    end else begin
                        raddr_d  = base_addr_i;
                        remain_d = num_tiles_i;
                        state_d  = c_READ;
                    end
                end
            end
            c_READ: begin
                cnt_d   = '0;
                state_d = c_WAIT;
            end
            c_WAIT: begin
                if (cnt_q == c_LAT_LAST) begin
                    fft_in_d = mem_rdata_i;
                    cnt_d    = '0;
                    state_d  = c_ISSUE;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            c_ISSUE: begin
                if (fft_ready_i) begin
                    remain_d = remain_q - 1'b1;
                    raddr_d  = raddr_q + stride_q;
                    cnt_d    = '0;
                    if (remain_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = c_DONE;
                    end else if (FFT_GAP > 0) begin
                        state_d = c_GAP;
                    end else begin
                        state_d = c_READ;
                    end
                end
            end
            c_GAP: begin
                if (cnt_q == c_GAP_LAST) begin
                    state_d = c_READ;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // fft_next follows fft_ready combinationally so the FFT sees the frame the cycle it is ready.
    always_comb begin
        fft_next_o = (state_q == c_ISSUE) && fft_ready_i;
        done_o     = (state_q == c_DONE);
    end

    assign mem_raddr_o = raddr_q;
    assign fft_in_o    = fft_in_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fft2d_tile_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft2d_tile_feeder
// Brief    : Self-checking bench; a tile-level event model predicts every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft2d_tile_feeder;

    localparam int AW     = 13;
    localparam int TB_ML  = 1;
    localparam int TB_GAP = 2;
    localparam int NCYC   = 512;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start_i = 1'b0;
    logic [AW-1:0]  base_addr_i = '0;
    logic [AW-1:0]  addr_stride_i = '0;
    logic [AW:0]    num_tiles_i = '0;
    logic [AW-1:0]  mem_raddr_o;
    logic [1023:0]  mem_rdata_i;
    logic           fft_ready_i = 1'b0;
    logic [1023:0]  fft_in_o;
    logic           fft_next_o;
    logic           busy_o;
    logic           done_o;

    fft2d_tile_feeder #(.ADDR_WIDTH(AW), .MEM_LATENCY(TB_ML), .FFT_GAP(TB_GAP)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .addr_stride_i(addr_stride_i),
        .num_tiles_i  (num_tiles_i),
        .mem_raddr_o  (mem_raddr_o),
        .mem_rdata_i  (mem_rdata_i),
        .fft_ready_i  (fft_ready_i),
        .fft_in_o     (fft_in_o),
        .fft_next_o   (fft_next_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    logic [31:0] salt = 32'h1234_5678;

    function automatic logic [1023:0] tile(input logic [AW-1:0] a);
        logic [1023:0] v;
        for (int s = 0; s < 16; s++) begin
            v[s*64 +: 64] = {(32'(a) * 32'h9E37_79B1) ^ salt,
                             (salt + 32'(s) * 32'h85EB_CA6B) ^ 32'(a)};
        end
        return v;
    endfunction

    // Memory with TB_ML cycles of read latency from the registered address.
    logic [1023:0] rd_pipe [TB_ML];
    always_ff @(posedge clk) begin
        rd_pipe[0] <= tile(mem_raddr_o);
        for (int i = 1; i < TB_ML; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata_i = rd_pipe[TB_ML-1];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int slot;
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            slot = 0;
            for (int s = 15; s >= 0; s--) if (obs[s*64 +: 64] !== exp[s*64 +: 64]) slot = s;
            $display("FAIL %s: slot%0d got=%h expected=%h", tag, slot,
                     obs[slot*64 +: 64], exp[slot*64 +: 64]);
        end
    endtask

    // Expected per-cycle behaviour, indexed by cycle relative to the start cycle.
    bit             ready_pat [NCYC];
    bit             e_next    [NCYC];
    bit             e_done    [NCYC];
    bit             e_busy    [NCYC];
    bit             e_rv      [NCYC];
    logic [AW-1:0]  e_raddr   [NCYC];
    bit             e_iv      [NCYC];
    logic [1023:0]  e_in      [NCYC];

    logic [AW-1:0]  m_raddr = '0;
    logic [1023:0]  m_in    = '0;
    int             obs_done;
    int             obs_next [$];

    task automatic model(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                         input logic [AW:0] num, output int done_c);
        logic [AW-1:0] a;
        int t, i;
        for (int c = 0; c < NCYC; c++) begin
            e_next[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_rv[c] = 0; e_iv[c] = 0;
            e_raddr[c] = '0; e_in[c] = '0;
        end
        if (num == 0) begin
            done_c = 1;
            for (int c = 1; c <= 3; c++) begin
                e_rv[c] = 1; e_raddr[c] = m_raddr; e_iv[c] = 1; e_in[c] = m_in;
            end
        end else begin
            a = base;
            t = 1;
            done_c = 0;
            for (int k = 0; k < int'(num); k++) begin
                i = t + 1 + TB_ML;
                while (!ready_pat[i] && i < NCYC - 8) i++;
                for (int c = t; c <= i; c++) begin e_rv[c] = 1; e_raddr[c] = a; end
                for (int c = t + 1 + TB_ML; c <= i; c++) begin e_iv[c] = 1; e_in[c] = tile(a); end
                e_next[i] = 1;
                m_in = tile(a);
                a = a + stride;
                if (k == int'(num) - 1) begin
                    done_c = i + 1;
                    for (int c = i + 1; c <= done_c + 1; c++) begin
                        e_rv[c] = 1; e_raddr[c] = a; e_iv[c] = 1; e_in[c] = m_in;
                    end
                end else begin
                    for (int c = i + 1; c <= i + TB_GAP; c++) begin e_rv[c] = 1; e_raddr[c] = a; end
                    t = i + 1 + TB_GAP;
                end
            end
            m_raddr = a;
        end
        e_done[done_c] = 1;
        for (int c = 1; c <= done_c; c++) e_busy[c] = 1;
    endtask

    // Runs one start; abort_c>0 pulses reset in that cycle, extra_c>0 re-pulses start mid-run.
    task automatic run(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                       input logic [AW:0] num, input int abort_c, input int extra_c);
        int done_c, len;
        model(base, stride, num, done_c);
        len = (abort_c > 0) ? abort_c + 2 : done_c + 2;
        obs_done = -1;
        obs_next.delete();
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = base; addr_stride_i = stride; num_tiles_i = num;
        fft_ready_i = ready_pat[0];
        for (int c = 1; c < len; c++) begin
            @(posedge clk); #1;
            start_i = (c == extra_c);
            if (c == extra_c) begin
                base_addr_i = AW'($urandom); addr_stride_i = AW'($urandom);
                num_tiles_i = (AW+1)'($urandom_range(1, 9));
            end
            reset = (c == abort_c);
            fft_ready_i = ready_pat[c];
            #3;
            if (done_o === 1'b1 && obs_done < 0) obs_done = c;
            if (fft_next_o === 1'b1) obs_next.push_back(c);
            if (abort_c > 0 && c == abort_c + 1) begin
                check($sformatf("abort_raddr_c%0d", c), 1024'(mem_raddr_o), '0);
                check($sformatf("abort_in_c%0d", c), fft_in_o, '0);
                check($sformatf("abort_next_c%0d", c), 1024'(fft_next_o), '0);
                check($sformatf("abort_busy_c%0d", c), 1024'(busy_o), '0);
                check($sformatf("abort_done_c%0d", c), 1024'(done_o), '0);
            end else begin
                check($sformatf("next_c%0d", c), 1024'(fft_next_o), 1024'(e_next[c]));
                check($sformatf("done_c%0d", c), 1024'(done_o), 1024'(e_done[c]));
                check($sformatf("busy_c%0d", c), 1024'(busy_o), 1024'(e_busy[c]));
                if (e_rv[c]) check($sformatf("raddr_c%0d", c), 1024'(mem_raddr_o), 1024'(e_raddr[c]));
                if (e_iv[c]) check($sformatf("fft_in_c%0d", c), fft_in_o, e_in[c]);
            end
        end
        start_i = 1'b0;
        reset = 1'b0;
        if (abort_c > 0) begin
            m_raddr = '0;
            m_in = '0;
        end
    endtask

    task automatic all_ready();
        for (int c = 0; c < NCYC; c++) ready_pat[c] = 1;
    endtask

    initial begin
        all_ready();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #3;
        check("rst_raddr", 1024'(mem_raddr_o), '0);
        check("rst_fft_in", fft_in_o, '0);
        check("rst_next", 1024'(fft_next_o), '0);
        check("rst_busy", 1024'(busy_o), '0);
        check("rst_done", 1024'(done_o), '0);

        // Basic three-tile run
        run(13'h100, 13'h1, 14'd3, 0, 0);
        check("t1_done_cycle", 1024'(obs_done), 1024'(14));
        check("t1_next_count", 1024'(obs_next.size()), 1024'(3));
        if (obs_next.size() == 3) check("t1_next2_cycle", 1024'(obs_next[1]), 1024'(8));

        // Back-pressure during cycles 8..10
        all_ready();
        for (int c = 8; c <= 10; c++) ready_pat[c] = 0;
        salt = 32'hCAFE_0001;
        run(13'h100, 13'h1, 14'd3, 0, 0);
        check("t2_done_cycle", 1024'(obs_done), 1024'(17));
        if (obs_next.size() == 3) check("t2_next2_cycle", 1024'(obs_next[1]), 1024'(11));
        else check("t2_next_count", 1024'(obs_next.size()), 1024'(3));

        // Empty run
        all_ready();
        run(13'h0AA, 13'h3, 14'd0, 0, 0);
        check("t3_done_cycle", 1024'(obs_done), 1024'(1));
        check("t3_no_next", 1024'(obs_next.size()), '0);

        // Address wrap
        salt = 32'h0BAD_F00D;
        run(13'h1FFF, 13'h2, 14'd2, 0, 0);
        check("t4_final_raddr", 1024'(mem_raddr_o), 1024'(13'h0003));

        // Start while busy is ignored
        run(13'h040, 13'h10, 14'd3, 0, 5);
        check("t5_next_count", 1024'(obs_next.size()), 1024'(3));

        // Reset mid-run, then a fresh start
        run(13'h100, 13'h1, 14'd3, 7, 0);
        check("t6_no_done", 1024'(obs_done), 1024'(-1));
        run(13'h200, 13'h5, 14'd2, 0, 0);

        // Randomized runs with random back-pressure
        for (int r = 0; r < 10; r++) begin
            logic [AW:0] n;
            salt = $urandom;
            for (int c = 0; c < NCYC; c++) ready_pat[c] = (c >= 400) ? 1'b1 : ($urandom_range(0, 9) < 7);
            n = (AW+1)'($urandom_range(0, 6));
            run(AW'($urandom), AW'($urandom), n, 0, (n >= 2) ? int'($urandom_range(2, 5)) : 0);
            check($sformatf("rand%0d_next_count", r), 1024'(obs_next.size()), 1024'(n));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
